// File: rtl/reg_file_32bit.sv
// reg_file_32bit: 2-read/1-write register file with optional write-through bypass and hard-wired zero register
module reg_file_32bit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b0,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  wr_en;

    assign wr_en = we && !(ZERO_REG && write_addr == '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[write_addr] = write_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // reset masks reads and bypass; the zero register wins over forwarding
    assign read_data1 = rst ? '0 :
                        (ZERO_REG && read_addr1 == '0) ? '0 :
                        (BYPASS && we && read_addr1 == write_addr) ? write_data :
                        mem_q[read_addr1];
    assign read_data2 = rst ? '0 :
                        (ZERO_REG && read_addr2 == '0) ? '0 :
                        (BYPASS && we && read_addr2 == write_addr) ? write_data :
                        mem_q[read_addr2];
endmodule

// File: tb/tb_reg_file_32bit.sv
// tb_reg_file_32bit: checks a default instance and a ZERO_REG=1/BYPASS=0 instance against an array model
module tb_reg_file_32bit;
    logic        clk = 0, rst = 0, we = 0;
    logic [4:0]  ra1 = 0, ra2 = 0, wa = 0;
    logic [31:0] wd = 0;
    logic [31:0] rd1a, rd2a, rd1b, rd2b;
    logic [31:0] m [2][32];
    int          n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    reg_file_32bit dut (
        .clk(clk), .rst(rst), .we(we), .read_addr1(ra1), .read_addr2(ra2),
        .write_addr(wa), .write_data(wd), .read_data1(rd1a), .read_data2(rd2a)
    );

    reg_file_32bit #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut_zb (
        .clk(clk), .rst(rst), .we(we), .read_addr1(ra1), .read_addr2(ra2),
        .write_addr(wa), .write_data(wd), .read_data1(rd1b), .read_data2(rd2b)
    );

    // model: config 0 = bypass, no zero reg; config 1 = zero reg, no bypass
    function automatic logic [31:0] model_rd(input int c, input logic [4:0] a);
        if (rst) return 32'h0;
        if (c == 1 && a == 0) return 32'h0;
        if (c == 0 && we && a == wa) return wd;
        return m[c][a];
    endfunction

    function automatic logic [31:0] obs(input int k);
        case (k)
            0: return rd1a;
            1: return rd2a;
            2: return rd1b;
            default: return rd2b;
        endcase
    endfunction

    function automatic logic [4:0] port_addr(input int k);
        return (k % 2 == 1) ? ra2 : ra1;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++) for (int i = 0; i < 32; i++) m[c][i] = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst && we) begin
            m[0][wa] = wd;
            if (wa != 0) m[1][wa] = wd;
        end
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1;
        model_clear();
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            for (int k = 0; k < 4; k++) begin
                n_total++;
                if (obs(k) !== 32'h0) $display("FAIL reset_clear out%0d addr=%0d got=%h exp=00000000", k, port_addr(k), obs(k));
                else n_pass++;
            end
        end
        we = 1; wa = 5'd4; wd = 32'h5555AAAA; ra1 = 5'd4;
        tick();
        #1;
        n_total++;
        if (rd1a !== 32'h0) $display("FAIL reset_bypass_write got=%h exp=00000000", rd1a);
        else n_pass++;
        we = 0;
        rst = 0;
        #1;
        n_total++;
        if (rd1a !== 32'h0 || rd1b !== 32'h0) $display("FAIL reset_write_ignored got=%h/%h exp=00000000", rd1a, rd1b);
        else n_pass++;
    endtask

    task automatic test_write_readback();
        for (int a = 0; a < 32; a++) begin
            we = 1; wa = 5'(a); wd = 32'hA5A50000 + 32'(a);
            tick();
        end
        we = 0;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(a) ^ 5'h1f;
            #1;
            for (int k = 0; k < 4; k++) begin
                n_total++;
                if (obs(k) !== model_rd(k / 2, port_addr(k)))
                    $display("FAIL readback out%0d addr=%0d got=%h exp=%h", k, port_addr(k), obs(k), model_rd(k / 2, port_addr(k)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_dual_read();
        we = 1; wa = 5'd3; wd = 32'h12345678;
        tick();
        wa = 5'd30; wd = 32'hDEADBEEF;
        tick();
        we = 0; ra1 = 5'd3; ra2 = 5'd3;
        #1;
        n_total++;
        if (rd1a !== 32'h12345678 || rd2a !== 32'h12345678 || rd1b !== 32'h12345678 || rd2b !== 32'h12345678)
            $display("FAIL dual_same got=%h %h %h %h exp=12345678", rd1a, rd2a, rd1b, rd2b);
        else n_pass++;
        ra2 = 5'd30;
        #1;
        n_total++;
        if (rd1a !== 32'h12345678 || rd2a !== 32'hDEADBEEF || rd1b !== 32'h12345678 || rd2b !== 32'hDEADBEEF)
            $display("FAIL dual_indep got=%h %h %h %h exp=12345678 deadbeef", rd1a, rd2a, rd1b, rd2b);
        else n_pass++;
    endtask

    task automatic test_bypass();
        we = 1; wa = 5'd7; wd = 32'h11111111;
        tick();
        wd = 32'h22222222; ra1 = 5'd7; ra2 = 5'd7;
        #1;
        n_total++;
        if (rd1a !== 32'h22222222 || rd2a !== 32'h22222222)
            $display("FAIL bypass_fwd got=%h %h exp=22222222", rd1a, rd2a);
        else n_pass++;
        n_total++;
        if (rd1b !== 32'h11111111 || rd2b !== 32'h11111111)
            $display("FAIL nobypass_old got=%h %h exp=11111111", rd1b, rd2b);
        else n_pass++;
        tick();
        we = 0;
        #1;
        n_total++;
        if (rd1a !== 32'h22222222 || rd1b !== 32'h22222222)
            $display("FAIL bypass_after got=%h %h exp=22222222", rd1a, rd1b);
        else n_pass++;
        we = 1; wa = 5'd0; wd = 32'h33333333; ra1 = 5'd0; ra2 = 5'd0;
        #1;
        n_total++;
        if (rd1a !== 32'h33333333 || rd1b !== 32'h0 || rd2b !== 32'h0)
            $display("FAIL zero_bypass got=%h %h %h exp=33333333 0 0", rd1a, rd1b, rd2b);
        else n_pass++;
        tick();
        we = 0;
        #1;
        n_total++;
        if (rd1a !== 32'h33333333 || rd1b !== 32'h0)
            $display("FAIL zero_write got=%h %h exp=33333333 00000000", rd1a, rd1b);
        else n_pass++;
    endtask

    task automatic test_hold();
        logic [31:0] prior;
        prior = m[0][9];
        we = 0; wa = 5'd9; wd = 32'hFFFFFFFF; ra1 = 5'd9; ra2 = 5'd9;
        repeat (3) tick();
        n_total++;
        if (rd1a !== prior || rd2b !== prior) $display("FAIL hold got=%h %h exp=%h", rd1a, rd2b, prior);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        we = 1; wa = 5'd20;
        for (int i = 1; i <= 3; i++) begin
            wd = 32'(i);
            tick();
        end
        we = 0; ra1 = 5'd20; ra2 = 5'd20;
        #1;
        n_total++;
        if (rd1a !== 32'd3 || rd2b !== 32'd3) $display("FAIL waw_last got=%h %h exp=00000003", rd1a, rd2b);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            if ($urandom_range(0, 7) == 0) ra1 = 5'd0;
            wd = $urandom;
            #1;
            for (int k = 0; k < 4; k++) begin
                n_total++;
                if (obs(k) !== model_rd(k / 2, port_addr(k)))
                    $display("FAIL random it=%0d out%0d addr=%0d got=%h exp=%h", n, k, port_addr(k), obs(k), model_rd(k / 2, port_addr(k)));
                else n_pass++;
            end
            tick();
        end
        we = 0;
    endtask

    task automatic test_async_reset();
        we = 1; wa = 5'd12; wd = 32'hCAFEF00D;
        tick();
        we = 0; ra1 = 5'd12; ra2 = 5'd12;
        #1;
        n_total++;
        if (rd1a !== 32'hCAFEF00D || rd1b !== 32'hCAFEF00D) $display("FAIL pre_reset got=%h %h exp=cafef00d", rd1a, rd1b);
        else n_pass++;
        #2 rst = 1;
        model_clear();
        #1;
        n_total++;
        if (rd1a !== 32'h0 || rd1b !== 32'h0) $display("FAIL async_reset got=%h %h exp=00000000", rd1a, rd1b);
        else n_pass++;
        rst = 0;
        #1;
        n_total++;
        if (rd1a !== 32'h0 || rd2b !== 32'h0) $display("FAIL async_cleared got=%h %h exp=00000000", rd1a, rd2b);
        else n_pass++;
        we = 1; wd = 32'h0BADF00D;
        @(negedge clk);
        rst = 1;
        tick();
        rst = 0; we = 0;
        #1;
        n_total++;
        if (rd1a !== 32'h0 || rd1b !== 32'h0) $display("FAIL reset_during_write got=%h %h exp=00000000", rd1a, rd1b);
        else n_pass++;
        we = 1; wd = 32'h600DCAFE;
        tick();
        we = 0;
        #1;
        n_total++;
        if (rd1a !== 32'h600DCAFE || rd2b !== 32'h600DCAFE) $display("FAIL first_write_after_reset got=%h %h exp=600dcafe", rd1a, rd2b);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_dual_read();
        test_bypass();
        test_hold();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
